// File: rtl/pcie_egress_reader.sv
// pcie_egress_reader: round-robin drain of output FIFOs 4..7
// into one valid/ready stream, with per-port delivery counters.
module pcie_egress_reader #(
  parameter int TAMANO_DATOS = 12,
  parameter int CNT_W        = 5,
  parameter int BUF_DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TAMANO_DATOS-1:0] data_in4,
  input  logic [TAMANO_DATOS-1:0] data_in5,
  input  logic [TAMANO_DATOS-1:0] data_in6,
  input  logic [TAMANO_DATOS-1:0] data_in7,
  input  logic [3:0]              empty,
  output logic [3:0]              pop,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic [1:0]              src_out,
  input  logic                    ready_in,
  input  logic                    req,
  input  logic [2:0]              idx,
  output logic [CNT_W-1:0]        cnt_data,
  output logic                    cnt_valid,
  output logic                    idle
);

  typedef enum logic [1:0] {
    S_RESET,
    S_INIT,
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]              r_rr;
  logic                    r_if_v;
  logic [1:0]              r_if_src;
  logic [TAMANO_DATOS-1:0] r_buf_d [2];
  logic [1:0]              r_buf_s [2];
  logic [1:0]              r_buf_n;
  logic [CNT_W-1:0]        r_cnt [4];
  logic [CNT_W-1:0]        r_cnt_data;
  logic                    r_cnt_valid;

  logic                    w_deq;
  logic [1:0]              w_occ;
  logic [2:0]              w_fill;
  logic                    w_room;
  logic                    w_any;
  logic [1:0]              w_sel;
  logic [1:0]              w_p;
  logic                    w_pop_en;
  logic [TAMANO_DATOS-1:0] w_cap;

  assign valid_out = (r_buf_n != 2'd0);
  assign data_out  = r_buf_d[0];
  assign src_out   = r_buf_s[0];
  assign cnt_data  = r_cnt_data;
  assign cnt_valid = r_cnt_valid;
  assign idle      = (r_state == S_IDLE);

  assign w_deq  = valid_out & ready_in;
  assign w_occ  = r_buf_n - {1'b0, w_deq};
  assign w_fill = {1'b0, w_occ} + {2'b0, r_if_v};
  assign w_room = (w_fill < 3'(BUF_DEPTH));

  assign w_pop_en = (r_state == S_ACTIVE) & w_any & w_room;
  assign pop      = w_pop_en ? (4'd1 << w_sel) : 4'd0;

  // first non-empty port at or above the RR pointer, wrapping
  always_comb begin
    w_any = 1'b0;
    w_sel = r_rr;
    w_p   = r_rr;
    for (int i = 3; i >= 0; i--) begin
      w_p = r_rr + 2'(i);
      if (!empty[w_p]) begin
        w_any = 1'b1;
        w_sel = w_p;
      end
    end
  end

  // read data of the FIFO popped last cycle
  always_comb begin
    w_cap = data_in4;
    unique case (r_if_src)
      2'd0: w_cap = data_in4;
      2'd1: w_cap = data_in5;
      2'd2: w_cap = data_in6;
      2'd3: w_cap = data_in7;
      default: w_cap = data_in4;
    endcase
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RESET:  w_state_nxt = S_INIT;
      S_INIT:   w_state_nxt = S_IDLE;
      S_IDLE:
        if (~&empty) w_state_nxt = S_ACTIVE;
      S_ACTIVE:
        if (&empty && !r_if_v && r_buf_n == 2'd0)
          w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_RESET;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_RESET;
    else        r_state <= w_state_nxt;
  end

  // pop bookkeeping: in-flight flag, its source, RR pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_if_v   <= 1'b0;
      r_if_src <= 2'd0;
      r_rr     <= 2'd0;
    end else begin
      r_if_v <= w_pop_en;
      if (w_pop_en) begin
        r_if_src <= w_sel;
        r_rr     <= w_sel + 2'd1;
      end
    end
  end

  // two-entry skid buffer, head in entry 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_buf_n <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_d[i] <= '0;
        r_buf_s[i] <= 2'd0;
      end
    end else begin
      if (w_deq) begin
        r_buf_d[0] <= r_buf_d[1];
        r_buf_s[0] <= r_buf_s[1];
      end
      if (r_if_v) begin
        r_buf_d[w_occ[0]] <= w_cap;
        r_buf_s[w_occ[0]] <= r_if_src;
      end
      r_buf_n <= w_occ + {1'b0, r_if_v};
    end
  end

  // per-port delivered-word counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (w_deq) begin
      r_cnt[r_buf_s[0]] <= r_cnt[r_buf_s[0]] + CNT_W'(1);
    end
  end

  // counter read port, one cycle latency
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt_valid <= 1'b0;
      r_cnt_data  <= '0;
    end else if (req && r_state != S_RESET) begin
      r_cnt_valid <= 1'b1;
      r_cnt_data  <= idx[2] ? '0 : r_cnt[idx[1:0]];
    end else begin
      r_cnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_egress_reader.sv
// tb_pcie_egress_reader: FIFO environment plus queue-based
// reference model for the egress reader.
module tb_pcie_egress_reader;

  typedef struct packed {
    logic [11:0] d;
    logic [1:0]  s;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] data_in4, data_in5, data_in6, data_in7;
  logic [3:0]  empty;
  logic [3:0]  pop;
  logic [11:0] data_out;
  logic        valid_out;
  logic [1:0]  src_out;
  logic        ready_in;
  logic        req;
  logic [2:0]  idx;
  logic [4:0]  cnt_data;
  logic        cnt_valid;
  logic        idle;

  pcie_egress_reader dut (
    .clk(clk), .reset(reset),
    .data_in4(data_in4), .data_in5(data_in5),
    .data_in6(data_in6), .data_in7(data_in7),
    .empty(empty), .pop(pop),
    .data_out(data_out), .valid_out(valid_out),
    .src_out(src_out), .ready_in(ready_in),
    .req(req), .idx(idx),
    .cnt_data(cnt_data), .cnt_valid(cnt_valid),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  logic [11:0] fq [4][$];
  word_t mbuf [$];
  word_t m_if;
  bit    m_if_v = 0;
  int    m_rr = 0;
  int    mcnt [4];
  bit    exp_cv = 0;
  int    exp_cd = 0;
  bit    prev_rst = 1;
  int    pend_k = -1;
  logic [11:0] pend_w;

  bit       rst_drv, rdy_drv, req_drv;
  logic [2:0] idx_drv;

  logic [3:0]  s_pop;
  logic        s_valid, s_cv, s_idle;
  logic [11:0] s_data;
  logic [4:0]  s_cd;

  int pop_cyc [$];
  int pop_port [$];
  int acc_cyc [$];
  int acc_src [$];
  int acc_dat [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick();
    for (int i = 0; i < 4; i++) begin
      int p;
      p = (m_rr + i) % 4;
      if (fq[p].size() > 0) return p;
    end
    return -1;
  endfunction

  task automatic clr_logs();
    pop_cyc.delete(); pop_port.delete();
    acc_cyc.delete(); acc_src.delete();
    acc_dat.delete();
  endtask

  task automatic tick();
    logic [11:0] din [4];
    word_t w;
    int k;
    bit deq;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      din[i] = (pend_k == i) ? pend_w : 12'($urandom);
    data_in4 = din[0]; data_in5 = din[1];
    data_in6 = din[2]; data_in7 = din[3];
    for (int i = 0; i < 4; i++)
      empty[i] = (fq[i].size() == 0);
    reset = rst_drv; ready_in = rdy_drv;
    req = req_drv; idx = idx_drv;
    #1;
    s_pop = pop; s_valid = valid_out;
    s_data = data_out; s_cv = cnt_valid;
    s_cd = cnt_data; s_idle = idle;
    chk("valid_out", valid_out, mbuf.size() != 0);
    if (mbuf.size() != 0) begin
      chk("data_out", data_out, mbuf[0].d);
      chk("src_out", src_out, mbuf[0].s);
    end
    chk("cnt_valid", cnt_valid, exp_cv);
    chk("cnt_data", cnt_data, exp_cd);
    deq = (mbuf.size() != 0) && rdy_drv;
    k = -1;
    if (pop != 4'd0) begin
      chk("pop_onehot", $onehot(pop), 1);
      for (int i = 0; i < 4; i++) if (pop[i]) k = i;
      chk("pop_port", k, rr_pick());
      chk("pop_room", (int'(mbuf.size()) - int'(deq)
                       + int'(m_if_v)) < 2, 1);
      chk("pop_idle", idle, 0);
    end
    pend_k = -1;
    if (!rst_drv) begin
      mbuf.delete(); m_if_v = 0; m_rr = 0;
      for (int i = 0; i < 4; i++) begin
        mcnt[i] = 0; fq[i].delete();
      end
      exp_cv = 0; exp_cd = 0;
    end else begin
      if (req_drv && !prev_rst) begin
        exp_cv = 1;
        exp_cd = (idx_drv < 4) ? mcnt[idx_drv] : 0;
      end else exp_cv = 0;
      if (deq) begin
        w = mbuf.pop_front();
        mcnt[w.s] = (mcnt[w.s] + 1) % 32;
        acc_cyc.push_back(cyc);
        acc_src.push_back(w.s);
        acc_dat.push_back(w.d);
      end
      if (m_if_v) mbuf.push_back(m_if);
      m_if_v = 0;
      if (k >= 0 && fq[k].size() > 0) begin
        m_if.d = fq[k].pop_front();
        m_if.s = 2'(k);
        m_if_v = 1;
        pend_k = k; pend_w = m_if.d;
        m_rr = (k + 1) % 4;
        pop_cyc.push_back(cyc);
        pop_port.push_back(k);
      end
    end
    prev_rst = !rst_drv;
    cyc++;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < 4; i++)
      if (fq[i].size() != 0) return 0;
    return (mbuf.size() == 0) && !m_if_v;
  endfunction

  task automatic wait_idle();
    int b;
    b = 0;
    do begin tick(); b++; end
    while (!(s_idle && all_done()) && b < 300);
    chk("idle_reached", s_idle, 1);
  endtask

  task automatic run_acc(input int n);
    int b;
    b = 0;
    while (acc_dat.size() < n && b < 300) begin
      tick(); b++;
    end
    chk("acc_count", acc_dat.size(), n);
  endtask

  task automatic do_reset();
    rst_drv = 0;
    tick(); tick();
    rst_drv = 1;
    wait_idle();
  endtask

  initial begin
    logic [11:0] w0, w1, w2;
    int n_push;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    rst_drv = 0; rdy_drv = 1; req_drv = 0; idx_drv = 0;
    reset = 0; ready_in = 1; req = 0; idx = 0;
    empty = 4'hF;
    data_in4 = 0; data_in5 = 0; data_in6 = 0; data_in7 = 0;

    // 1: reset and bring-up
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pop", s_pop, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_data", s_data, 0);
      chk("rst_cv", s_cv, 0);
      chk("rst_cd", s_cd, 0);
      chk("rst_idle", s_idle, 0);
    end
    rst_drv = 1;
    tick();
    chk("st_reset_idle", s_idle, 0);
    tick();
    chk("init_idle", s_idle, 0);
    chk("init_pop", s_pop, 0);
    tick();
    chk("idle_up", s_idle, 1);

    // 2: single port, two words
    clr_logs();
    fq[1].push_back(12'h0A4);
    fq[1].push_back(12'h015);
    run_acc(2);
    chk("t2_port0", pop_port[0], 1);
    chk("t2_port1", pop_port[1], 1);
    chk("t2_consec", pop_cyc[1] - pop_cyc[0], 1);
    chk("t2_lat0", acc_cyc[0] - pop_cyc[0], 2);
    chk("t2_lat1", acc_cyc[1] - pop_cyc[1], 2);
    chk("t2_dat0", acc_dat[0], 12'h0A4);
    chk("t2_dat1", acc_dat[1], 12'h015);
    chk("t2_src", acc_src[1], 1);
    wait_idle();

    // 3: all ports, round robin from pointer 0
    do_reset();
    clr_logs();
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 2; j++)
        fq[p].push_back(12'($urandom));
    run_acc(8);
    for (int i = 0; i < 5; i++) begin
      chk("t3_pop", pop_port[i], i % 4);
      chk("t3_src", acc_src[i], i % 4);
    end
    wait_idle();

    // 4: back-pressure
    clr_logs();
    rdy_drv = 0;
    w0 = 12'($urandom); w1 = 12'($urandom);
    w2 = 12'($urandom);
    fq[2].push_back(w0); fq[2].push_back(w1);
    fq[2].push_back(w2);
    for (int i = 0; i < 8; i++) tick();
    chk("t4_pops", pop_port.size(), 2);
    chk("t4_hold_v", s_valid, 1);
    chk("t4_hold_d", s_data, w0);
    rdy_drv = 1;
    run_acc(3);
    chk("t4_resume", pop_port.size(), 3);
    chk("t4_d0", acc_dat[0], w0);
    chk("t4_d1", acc_dat[1], w1);
    chk("t4_d2", acc_dat[2], w2);
    wait_idle();

    // random traffic
    clr_logs();
    n_push = 0;
    for (int i = 0; i < 400; i++) begin
      int p;
      rdy_drv = ($urandom_range(0, 3) != 0);
      req_drv = $urandom_range(0, 1);
      idx_drv = 3'($urandom);
      p = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0 && fq[p].size() < 8) begin
        fq[p].push_back(12'($urandom));
        n_push++;
      end
      tick();
    end
    rdy_drv = 1; req_drv = 0;
    wait_idle();
    chk("rand_drain", acc_dat.size(), n_push);

    // 5: counter wrap and read port
    do_reset();
    clr_logs();
    for (int i = 0; i < 33; i++)
      fq[0].push_back(12'($urandom));
    run_acc(33);
    req_drv = 1; idx_drv = 0;
    tick();
    idx_drv = 4;
    tick();
    chk("t5_cv", s_cv, 1);
    chk("t5_wrap", s_cd, 1);
    req_drv = 0;
    tick();
    chk("t5_cv4", s_cv, 1);
    chk("t5_idx4", s_cd, 0);
    tick();
    chk("t5_cv_off", s_cv, 0);
    chk("t5_hold", s_cd, 0);
    wait_idle();

    // 6: reset with words outstanding
    clr_logs();
    fq[1].push_back(12'($urandom));
    fq[1].push_back(12'($urandom));
    run_acc(2);
    clr_logs();
    rdy_drv = 0;
    for (int p = 0; p < 3; p++)
      fq[3].push_back(12'($urandom));
    for (int b = 0; b < 20 && pop_port.size() < 2; b++)
      tick();
    chk("t6_pops", pop_port.size(), 2);
    rst_drv = 0;
    tick();
    tick();
    chk("t6_valid", s_valid, 0);
    chk("t6_pop", s_pop, 0);
    chk("t6_cv", s_cv, 0);
    chk("t6_cd", s_cd, 0);
    chk("t6_idle", s_idle, 0);
    rst_drv = 1;
    wait_idle();
    chk("t6_discard", acc_dat.size(), 0);
    req_drv = 1; idx_drv = 1;
    tick();
    req_drv = 0;
    tick();
    chk("t6_rd_v", s_cv, 1);
    chk("t6_cnt0", s_cd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
